// File: rtl/stack_cmd_ctrl.sv
// Push/pop command front-end for a hardware stack: synchronizes and debounces two
// raw buttons, turns each press into at most one registered strobe, and tracks misuse.
module stack_cmd_ctrl #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             btn_push,
    input  logic             btn_pop,
    input  logic [WIDTH-1:0] sw,
    input  logic             full,
    input  logic             empty,
    output logic             push,
    output logic             pop,
    output logic [WIDTH-1:0] din,
    output logic             ovf,
    output logic             udf
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_REL = 1'b1
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    // Bit 0 carries the push button, bit 1 the pop button.
    logic [1:0]       meta_q, sync_q;
    logic [1:0]       deb_q, deb_d, deb_prev_q, rise_q;
    logic [15:0]      cnt_q [2];
    logic [15:0]      cnt_d [2];

    state_t           state_q, state_d;
    logic             push_q, push_d, pop_q, pop_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic [WIDTH-1:0] din_q, din_d;

    // Two-flop synchronizer for both raw buttons
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= {btn_pop, btn_push};
            sync_q <= meta_q;
        end
    end

    // Debounce next-state: count consecutive disagreeing cycles, accept on the last one
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] == deb_q[i]) begin
                cnt_d[i] = 16'd0;
            end else if (cnt_q[i] == DB_LAST) begin
                deb_d[i] = sync_q[i];
                cnt_d[i] = 16'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Debounced levels, counters and registered rise pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            deb_q      <= 2'b00;
            deb_prev_q <= 2'b00;
            rise_q     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            rise_q     <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Command FSM: one decision per press, then wait until both buttons are released
    always_comb begin
        state_d = state_q;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        din_d   = din_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        case (state_q)
            IDLE: begin
                if (rise_q[0] && rise_q[1]) begin
                    state_d = WAIT_REL;
                end else if (rise_q[0]) begin
                    state_d = WAIT_REL;
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_d = 1'b1;
                        din_d  = sw;
                        ovf_d  = 1'b0;
                    end
                end else if (rise_q[1]) begin
                    state_d = WAIT_REL;
                    if (empty) begin
                        udf_d = 1'b1;
                    end else begin
                        pop_d = 1'b1;
                        udf_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_REL: begin
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_REL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            din_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            din_q   <= din_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign push = push_q;
    assign pop  = pop_q;
    assign din  = din_q;
    assign ovf  = ovf_q;
    assign udf  = udf_q;

endmodule
